// File: rtl/demux1to2_buf.sv
// demux1to2_buf: 1-to-2 demultiplexer with a FIFO on each output.
// Each accepted input word is routed by in_sel into FIFO 0 or FIFO 1. A
// stalled consumer only blocks input words that are bound for its own full FIFO.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_sel        word to route and its destination
//   in_valid/in_ready     input handshake (in_ready depends only on in_sel and occupancy)
//   outN_data/outN_valid  head of FIFO N (data forced to 0 while empty)
//   outN_ready            consumer N pops the head word
//   accN_cnt              words accepted for output N since reset (wrapping)
module demux1to2_buf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] acc0_cnt,
   output logic [CNT_W-1:0] acc1_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem    [2][DEPTH];
   logic [PW-1:0]    rd_ptr [2];
   logic [PW-1:0]    wr_ptr [2];
   logic [CW-1:0]    count  [2];
   logic [CNT_W-1:0] acc    [2];

   logic [1:0] full;
   logic [1:0] empty;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] rdy;

   assign rdy = {out1_ready, out0_ready};

   // Occupancy flags and per-FIFO handshake decode
   always_comb begin
      full  = '0;
      empty = '0;
      push  = '0;
      pop   = '0;
      for (int n = 0; n < 2; n++) begin
         full[n]  = (count[n] == CW'(DEPTH));
         empty[n] = (count[n] == '0);
         push[n]  = in_valid & in_ready & (in_sel == 1'(n));
         pop[n]   = ~empty[n] & rdy[n];
      end
   end

   // A full FIFO refuses the word even if it pops this cycle (no bypass)
   assign in_ready = ~reset & ~full[in_sel];

   // Pointers, occupancy and accept counters
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (reset) begin
            rd_ptr[n] <= '0;
            wr_ptr[n] <= '0;
            count[n]  <= '0;
            acc[n]    <= '0;
         end else begin
            if (push[n]) begin
               wr_ptr[n] <= wr_ptr[n] + PW'(1);
               acc[n]    <= acc[n] + CNT_W'(1);
            end
            if (pop[n]) begin
               rd_ptr[n] <= rd_ptr[n] + PW'(1);
            end
            case ({push[n], pop[n]})
               2'b10:   count[n] <= count[n] + CW'(1);
               2'b01:   count[n] <= count[n] - CW'(1);
               default: count[n] <= count[n];
            endcase
         end
      end
   end

   // Storage is not reset; stale entries are masked by the empty flag
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) begin
            mem[n][wr_ptr[n]] <= in_data;
         end
      end
   end

   assign out0_valid = ~empty[0];
   assign out1_valid = ~empty[1];
   assign out0_data  = empty[0] ? '0 : mem[0][rd_ptr[0]];
   assign out1_data  = empty[1] ? '0 : mem[1][rd_ptr[1]];
   assign acc0_cnt   = acc[0];
   assign acc1_cnt   = acc[1];

endmodule
